video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Generates raster timing for the GPU display path: free-running horizontal/vertical counters, active-low sync, and a blank flag. It sits directly upstream of the pixel-plane renderer and feeds it `h_count`, `v_count`, `hs`, `vs` and `blank`. Two fixed modes are supported:

- 640x480@60 for HDMI (`scale2x=1`).
- 240p NTSC (`scale2x=0`).

The mode is latched only at frame boundaries, so a mode change never produces a torn frame.

## Interface
Parameters:
- `PIPE_DLY`, default 1: cycles by which `hs`/`vs`/`blank` lag the counters, matching VRAM read latency. Legal range 0..3.

Ports:
- `clk` input 1: pixel clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `scale2x` input 1: mode request (1 = HDMI 640x480, 0 = NTSC 240p).
- `mode` output 1: currently latched mode, driven to the renderer's `scale2x`.
- `h_count` output 12: pixel position in line, including blanking.
- `v_count` output 12: line position in frame, including blanking.
- `hs` output 1: horizontal sync, active-low.
- `vs` output 1: vertical sync, active-low.
- `blank` output 1: 1 outside the active area.
- `frame_drawn` output 1: 1-cycle pulse at start of each frame.
- `line_cmp` input 10: line-interrupt compare value. Present only with the macro.
- `line_irq` output 1: 1-cycle line-match pulse.

## Operation
- Counters are registered. `h_count` increments every clk and wraps at H_TOT-1 to 0. `v_count` increments when `h_count` wraps, and wraps at V_TOT-1 to 0.
- Blanking precedes the active region in both axes. Each axis runs front porch, sync, back porch, then active.
- HDMI horizontal (H_TOT 800):
  - `hs` low for h 16..111.
  - Active h 160..799.
- HDMI vertical (V_TOT 525):
  - `vs` low for v 10..11.
  - Active v 45..524.
- NTSC horizontal (H_TOT 858):
  - `hs` low for h 16..79.
  - Active h 196..835; h 836..857 is blank.
- NTSC vertical (V_TOT 262):
  - `vs` low for v 4..6.
  - Active v 20..259; v 260..261 is blank.
- `blank` = NOT(h_active AND v_active).
- `hs`/`vs`/`blank` are decoded from the counters, then passed through a PIPE_DLY-deep register chain. With PIPE_DLY=0 they are combinational from the counters.
- Mode latch: `mode` loads `scale2x` on the cycle with h=H_TOT-1 and v=V_TOT-1. The new totals and decodes apply from the (0,0) cycle onward. Changes to `scale2x` at any other time are ignored until that point.
- `frame_drawn` is registered, high for exactly the cycle where h=0 and v=0. It is suppressed for the first (0,0) cycle after reset release.
- All comparisons are unsigned 12-bit against the current mode's constants.

## Timing
- Reset (`reset_n` low at a clk edge):
  - next cycle `h_count`=0, `v_count`=0.
  - `hs`=1, `vs`=1, `blank`=1.
  - `frame_drawn`=0, `line_irq`=0.
  - `mode`=`scale2x` sampled at that edge.
  - the whole delay chain loads inactive values.
- Reset mid-line or mid-frame aborts immediately; there is no partial-frame pulse.
- First count after release: the cycle after the first edge with `reset_n`=1 shows h=1.
- Sync/blank latency: the outputs at cycle t reflect the counter values at t-PIPE_DLY.
- Simultaneous `scale2x` change and frame wrap: the value sampled on the wrap cycle wins.
- Frame period: 420000 clk in HDMI, 224796 clk in NTSC.

## Configuration
- `VIDEO_TIMING_LINE_IRQ_EN` defined:
  - `line_cmp` port exists.
  - `line_irq` is registered and high for one cycle when h=0 and v=`line_cmp` (raw line, zero-extended).
  - A value ≥ V_TOT never fires.
  - `line_cmp` is sampled each cycle.
- Undefined: `line_cmp` is absent and `line_irq` is tied 0.

## Test plan
- HDMI, PIPE_DLY=1, reset released → h wraps 799→0 with v+1, and v wraps 524→0. `hs` is low for exactly 96 cycles per line, lagging h 16 by one cycle. `blank`=0 exactly for counts h160..799 and v45..524, shifted +1 cycle.
- NTSC → line is 858 clk and frame is 262 lines. `vs` is low during lines 4..6. Active counts are h196..835 and v20..259; `blank`=1 at h836..857.
- `scale2x` toggled 1→0 at v=200 → HDMI totals persist until (799,524), then NTSC totals start at (0,0) and `mode` flips on that cycle.
- `frame_drawn` → no pulse at the first (0,0) after reset, then exactly one pulse every 420000 clk (HDMI).
- `reset_n` low for 2 cycles at h=300, v=100 → counters 0/0, `hs`/`vs`/`blank` inactive, no `frame_drawn` pulse, and counting resumes cleanly.
- Macro on:
  - `line_cmp`=100 → one `line_irq` pulse per frame at h=0, v=100.
  - `line_cmp`=600 in HDMI → no pulse.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the GPU display path.
// Two fixed modes, selected by the latched `mode` bit:
//   mode=1 : 640x480@60 HDMI  (800 x 525 totals)
//   mode=0 : 240p NTSC        (858 x 262 totals)
// Blanking precedes the active region on both axes:
// front porch, sync, back porch, then active.
//
// Parameters:
//   PIPE_DLY    - cycles by which hs/vs/blank lag the counters (0..3).
//
// Ports:
//   clk         - pixel clock
//   reset_n     - synchronous active-low reset
//   scale2x     - mode request, latched only at the frame wrap
//   line_cmp    - line-interrupt compare value (macro builds only)
//   mode        - currently latched mode
//   h_count     - pixel position in line, blanking included
//   v_count     - line position in frame, blanking included
//   hs, vs      - active-low syncs, delayed by PIPE_DLY
//   blank       - 1 outside the active area, delayed by PIPE_DLY
//   frame_drawn - 1-cycle pulse on each (0,0) cycle reached by counting
//   line_irq    - 1-cycle pulse at h=0, v=line_cmp
//
// Optional feature macro: VIDEO_TIMING_LINE_IRQ_EN
//   defined   : line_cmp port exists and line_irq is live.
//   undefined : no line_cmp port, line_irq tied low.

module video_timing_gen #(
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scale2x,
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    input  logic [9:0]  line_cmp,
`endif
    output logic        mode,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        frame_drawn,
    output logic        line_irq
);

    // HDMI 640x480@60 timing
    localparam logic [11:0] HD_H_LAST = 12'd799;
    localparam logic [11:0] HD_HS_BEG = 12'd16;
    localparam logic [11:0] HD_HS_END = 12'd111;
    localparam logic [11:0] HD_HA_BEG = 12'd160;
    localparam logic [11:0] HD_HA_END = 12'd799;
    localparam logic [11:0] HD_V_LAST = 12'd524;
    localparam logic [11:0] HD_VS_BEG = 12'd10;
    localparam logic [11:0] HD_VS_END = 12'd11;
    localparam logic [11:0] HD_VA_BEG = 12'd45;
    localparam logic [11:0] HD_VA_END = 12'd524;

    // NTSC 240p timing
    localparam logic [11:0] NT_H_LAST = 12'd857;
    localparam logic [11:0] NT_HS_BEG = 12'd16;
    localparam logic [11:0] NT_HS_END = 12'd79;
    localparam logic [11:0] NT_HA_BEG = 12'd196;
    localparam logic [11:0] NT_HA_END = 12'd835;
    localparam logic [11:0] NT_V_LAST = 12'd261;
    localparam logic [11:0] NT_VS_BEG = 12'd4;
    localparam logic [11:0] NT_VS_END = 12'd6;
    localparam logic [11:0] NT_VA_BEG = 12'd20;
    localparam logic [11:0] NT_VA_END = 12'd259;

    logic [11:0] h_last;
    logic [11:0] hs_beg;
    logic [11:0] hs_end;
    logic [11:0] ha_beg;
    logic [11:0] ha_end;
    logic [11:0] v_last;
    logic [11:0] vs_beg;
    logic [11:0] vs_end;
    logic [11:0] va_beg;
    logic [11:0] va_end;

    logic        h_wrap;
    logic        v_wrap;
    logic        f_wrap;
    logic [11:0] h_next;
    logic [11:0] v_next;

    logic        h_act;
    logic        v_act;
    logic        hs_dec;
    logic        vs_dec;
    logic        blank_dec;

    // Constants follow the latched mode, so a frame never mixes
    // the totals or decodes of two modes.
    always_comb begin
        h_last = HD_H_LAST;
        hs_beg = HD_HS_BEG;
        hs_end = HD_HS_END;
        ha_beg = HD_HA_BEG;
        ha_end = HD_HA_END;
        v_last = HD_V_LAST;
        vs_beg = HD_VS_BEG;
        vs_end = HD_VS_END;
        va_beg = HD_VA_BEG;
        va_end = HD_VA_END;
        unique case (mode)
            1'b1: begin
                h_last = HD_H_LAST;
                hs_beg = HD_HS_BEG;
                hs_end = HD_HS_END;
                ha_beg = HD_HA_BEG;
                ha_end = HD_HA_END;
                v_last = HD_V_LAST;
                vs_beg = HD_VS_BEG;
                vs_end = HD_VS_END;
                va_beg = HD_VA_BEG;
                va_end = HD_VA_END;
            end
            1'b0: begin
                h_last = NT_H_LAST;
                hs_beg = NT_HS_BEG;
                hs_end = NT_HS_END;
                ha_beg = NT_HA_BEG;
                ha_end = NT_HA_END;
                v_last = NT_V_LAST;
                vs_beg = NT_VS_BEG;
                vs_end = NT_VS_END;
                va_beg = NT_VA_BEG;
                va_end = NT_VA_END;
            end
        endcase
    end

    // Next-count logic
    always_comb begin
        h_wrap = (h_count == h_last);
        v_wrap = (v_count == v_last);
        f_wrap = h_wrap && v_wrap;
        h_next = h_wrap ? 12'd0 : h_count + 12'd1;
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? 12'd0 : v_count + 12'd1;
        end
    end

    // Counters, mode latch and frame pulse. The reset state shows
    // (0,0) with frame_drawn low, so only a real frame wrap pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_count     <= 12'd0;
            v_count     <= 12'd0;
            mode        <= scale2x;
            frame_drawn <= 1'b0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            frame_drawn <= f_wrap;
            if (f_wrap) begin
                mode <= scale2x;
            end
        end
    end

    // Sync / blank decode from the current counters
    always_comb begin
        h_act     = (h_count >= ha_beg) && (h_count <= ha_end);
        v_act     = (v_count >= va_beg) && (v_count <= va_end);
        hs_dec    = !((h_count >= hs_beg) && (h_count <= hs_end));
        vs_dec    = !((v_count >= vs_beg) && (v_count <= vs_end));
        blank_dec = !(h_act && v_act);
    end

    // Delay chain aligning sync/blank with the VRAM read latency.
    // Bit order in each stage: {hs, vs, blank}.
    if (PIPE_DLY == 0) begin : g_comb
        assign hs    = hs_dec;
        assign vs    = vs_dec;
        assign blank = blank_dec;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIPE_DLY];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= 3'b111;
                end
            end else begin
                pipe_q[0] <= {hs_dec, vs_dec, blank_dec};
                for (int i = 1; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign hs    = pipe_q[PIPE_DLY-1][2];
        assign vs    = pipe_q[PIPE_DLY-1][1];
        assign blank = pipe_q[PIPE_DLY-1][0];
    end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    // Registered from the next counts so the pulse lands on the
    // (0, line_cmp) cycle itself. Lines past the frame never match.
    logic irq_hit;

    always_comb begin
        irq_hit = (h_next == 12'd0) && (v_next == {2'b00, line_cmp});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= irq_hit;
        end
    end
`else
    assign line_irq = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed scoreboard bench for video_timing_gen.
// Stimulus queues expected values; a negedge monitor checks them.

module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scale2x = 1'b0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic [9:0]  line_cmp = 10'd10;
`endif
    logic        mode;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        frame_drawn;
    logic        line_irq;

    always #5 clk = ~clk;

    video_timing_gen #(
        .PIPE_DLY(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .scale2x(scale2x),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        .line_cmp(line_cmp),
`endif
        .mode(mode),
        .h_count(h_count),
        .v_count(v_count),
        .hs(hs),
        .vs(vs),
        .blank(blank),
        .frame_drawn(frame_drawn),
        .line_irq(line_irq)
    );

    typedef enum int {
        K_H, K_V, K_HS, K_VS, K_BLANK, K_MODE, K_FD, K_IRQ,
        K_HSLOW, K_VSLOW, K_FDN, K_IRQN, K_CLR
    } kind_e;

    typedef struct {
        string name;
        kind_e kind;
        int    exp;
    } vec_t;

    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   hs_low = 0;
    int   vs_low = 0;
    int   fd_n = 0;
    int   irq_n = 0;

    always @(negedge clk) begin
        vec_t v;
        int   act;
        if (hs === 1'b0) hs_low++;
        if (vs === 1'b0) vs_low++;
        if (frame_drawn === 1'b1) fd_n++;
        if (line_irq === 1'b1) irq_n++;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            if (v.kind == K_CLR) begin
                case (v.exp)
                    0: hs_low = 0;
                    1: vs_low = 0;
                    2: fd_n = 0;
                    default: irq_n = 0;
                endcase
            end else begin
                case (v.kind)
                    K_H:     act = int'(h_count);
                    K_V:     act = int'(v_count);
                    K_HS:    act = (hs === 1'b1) ? 1 : 0;
                    K_VS:    act = (vs === 1'b1) ? 1 : 0;
                    K_BLANK: act = (blank === 1'b1) ? 1 : 0;
                    K_MODE:  act = (mode === 1'b1) ? 1 : 0;
                    K_FD:    act = (frame_drawn === 1'b1) ? 1 : 0;
                    K_IRQ:   act = (line_irq === 1'b1) ? 1 : 0;
                    K_HSLOW: act = hs_low;
                    K_VSLOW: act = vs_low;
                    K_FDN:   act = fd_n;
                    default: act = irq_n;
                endcase
                n_vec++;
                if (act != v.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0d, want %0d",
                             v.name, act, v.exp);
                end
            end
        end
    end

    int eh = 0;
    int ev = 0;
    bit em = 1'b0;

    function automatic int h_tot(bit m);
        return m ? 800 : 858;
    endfunction

    function automatic int v_tot(bit m);
        return m ? 525 : 262;
    endfunction

    task automatic push(string n, kind_e k, int e);
        vec_t v;
        v.name = n;
        v.kind = k;
        v.exp  = e;
        sb.push_back(v);
    endtask

    task automatic chk_now(string n, int act, int e);
        n_vec++;
        if (act != e) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", n, act, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            eh = 0;
            ev = 0;
            em = scale2x;
        end else if (eh == h_tot(em) - 1) begin
            eh = 0;
            if (ev == v_tot(em) - 1) begin
                ev = 0;
                em = scale2x;
            end else begin
                ev++;
            end
        end else begin
            eh++;
        end
        #1;
    endtask

    task automatic goto(int h, int v);
        for (int i = 0; i < 500000; i++) begin
            if (eh == h && ev == v) return;
            step();
        end
        n_vec++;
        n_bad++;
        $display("FAIL goto_timeout: wait for (%0d,%0d) expired",
                 h, v);
    endtask

    initial begin
        step();
        step();
        chk_now("rst_h_now", int'(h_count), 0);
        chk_now("rst_v_now", int'(v_count), 0);
        chk_now("rst_hs_now", (hs === 1'b1) ? 1 : 0, 1);
        chk_now("rst_vs_now", (vs === 1'b1) ? 1 : 0, 1);
        chk_now("rst_blank_now", (blank === 1'b1) ? 1 : 0, 1);
        chk_now("rst_fd_now", (frame_drawn === 1'b1) ? 1 : 0, 0);
        chk_now("rst_irq_now", (line_irq === 1'b1) ? 1 : 0, 0);
        chk_now("rst_mode_now", (mode === 1'b1) ? 1 : 0, 0);
        push("rst_h", K_H, 0);
        push("rst_v", K_V, 0);
        push("rst_hs", K_HS, 1);
        push("rst_vs", K_VS, 1);
        push("rst_blank", K_BLANK, 1);
        push("rst_fd", K_FD, 0);
        push("rst_irq", K_IRQ, 0);
        push("rst_mode", K_MODE, 0);
        reset_n = 1'b1;
        step();
        push("first_h", K_H, 1);
        push("first_v", K_V, 0);

        goto(16, 0);
        push("nt_hs_16", K_HS, 1);
        step();
        push("nt_hs_17", K_HS, 0);
        goto(80, 0);
        push("nt_hs_80", K_HS, 0);
        step();
        push("nt_hs_81", K_HS, 1);
        goto(857, 0);
        push("nt_h_last", K_H, 857);
        step();
        push("nt_h_wrap", K_H, 0);
        push("nt_v_inc", K_V, 1);
        push("clr", K_CLR, 0);
        goto(0, 2);
        push("nt_hs_width", K_HSLOW, 64);

        goto(0, 3);
        push("clr", K_CLR, 1);
        goto(0, 4);
        push("nt_vs_v4a", K_VS, 1);
        step();
        push("nt_vs_v4b", K_VS, 0);
        goto(0, 7);
        push("nt_vs_v7a", K_VS, 0);
        step();
        push("nt_vs_v7b", K_VS, 1);
        goto(0, 8);
        push("nt_vs_width", K_VSLOW, 2574);

`ifdef VIDEO_TIMING_LINE_IRQ_EN
        push("clr", K_CLR, 3);
        goto(0, 10);
        push("nt_irq_hit", K_IRQ, 1);
        step();
        push("nt_irq_end", K_IRQ, 0);
        goto(0, 12);
        push("nt_irq_cnt", K_IRQN, 1);
`endif

        goto(500, 19);
        push("nt_blank_v19", K_BLANK, 1);
        goto(196, 20);
        push("nt_blank_196", K_BLANK, 1);
        step();
        push("nt_blank_197", K_BLANK, 0);
        goto(836, 20);
        push("nt_blank_836", K_BLANK, 0);
        step();
        push("nt_blank_837", K_BLANK, 1);
        push("nt_mode", K_MODE, 0);

        goto(300, 100);
        reset_n = 1'b0;
        scale2x = 1'b1;
        step();
        chk_now("mid_rst_h_now", int'(h_count), 0);
        chk_now("mid_rst_v_now", int'(v_count), 0);
        chk_now("mid_rst_hs_now", (hs === 1'b1) ? 1 : 0, 1);
        chk_now("mid_rst_vs_now", (vs === 1'b1) ? 1 : 0, 1);
        chk_now("mid_rst_blank_now", (blank === 1'b1) ? 1 : 0, 1);
        chk_now("mid_rst_fd_now", (frame_drawn === 1'b1) ? 1 : 0, 0);
        push("mid_rst_h", K_H, 0);
        push("mid_rst_v", K_V, 0);
        push("mid_rst_hs", K_HS, 1);
        push("mid_rst_vs", K_VS, 1);
        push("mid_rst_blank", K_BLANK, 1);
        push("mid_rst_fd", K_FD, 0);
        push("mid_rst_mode", K_MODE, 1);
        step();
        push("mid_rst_fd2", K_FD, 0);
        push("mid_rst_h2", K_H, 0);
        reset_n = 1'b1;
        step();
        push("resume_h", K_H, 1);
        push("resume_v", K_V, 0);
        push("clr", K_CLR, 2);

        goto(16, 0);
        push("hd_hs_16", K_HS, 1);
        step();
        push("hd_hs_17", K_HS, 0);
        goto(112, 0);
        push("hd_hs_112", K_HS, 0);
        step();
        push("hd_hs_113", K_HS, 1);
        goto(799, 0);
        push("hd_h_last", K_H, 799);
        step();
        push("hd_h_wrap", K_H, 0);
        push("hd_v_inc", K_V, 1);
        push("clr", K_CLR, 0);
        goto(0, 2);
        push("hd_hs_width", K_HSLOW, 96);

        goto(0, 9);
        push("clr", K_CLR, 1);
        goto(0, 10);
        push("hd_vs_v10a", K_VS, 1);
        step();
        push("hd_vs_v10b", K_VS, 0);
        goto(0, 12);
        push("hd_vs_v12a", K_VS, 0);
        step();
        push("hd_vs_v12b", K_VS, 1);
        goto(0, 13);
        push("hd_vs_width", K_VSLOW, 1600);

        goto(500, 44);
        push("hd_blank_v44", K_BLANK, 1);
        goto(160, 45);
        push("hd_blank_160", K_BLANK, 1);
        step();
        push("hd_blank_161", K_BLANK, 0);
        goto(0, 46);
        push("hd_blank_eol", K_BLANK, 0);
        step();
        push("hd_blank_sol", K_BLANK, 1);

`ifdef VIDEO_TIMING_LINE_IRQ_EN
        line_cmp = 10'd100;
        push("clr", K_CLR, 3);
        goto(0, 100);
        push("hd_irq_hit", K_IRQ, 1);
        step();
        push("hd_irq_end", K_IRQ, 0);
        goto(0, 150);
        push("hd_irq_cnt", K_IRQN, 1);
        line_cmp = 10'd600;
        push("clr", K_CLR, 3);
`endif

        goto(0, 200);
        scale2x = 1'b0;
        push("hd_mode_v200", K_MODE, 1);
        goto(0, 400);
        push("hd_mode_v400", K_MODE, 1);
        goto(400, 524);
        push("hd_blank_v524", K_BLANK, 0);

        goto(798, 524);
        scale2x = 1'b1;
        step();
        scale2x = 1'b0;
        push("wrap_mode_old", K_MODE, 1);
        push("wrap_h", K_H, 799);
        push("wrap_v", K_V, 524);
        push("fd_none", K_FDN, 0);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
        push("hd_irq_600", K_IRQN, 0);
`endif
        step();
        push("new_mode", K_MODE, 0);
        push("fd_pulse", K_FD, 1);
        push("f0_h", K_H, 0);
        push("f0_v", K_V, 0);
        push("f0_blank", K_BLANK, 0);
        step();
        push("f1_blank", K_BLANK, 1);
        push("fd_end", K_FD, 0);
        push("fd_count", K_FDN, 1);

        goto(857, 0);
        push("sw_h_last", K_H, 857);
        step();
        push("sw_h_wrap", K_H, 0);
        push("sw_v_inc", K_V, 1);
        goto(80, 1);
        push("sw_hs_80", K_HS, 0);
        step();
        push("sw_hs_81", K_HS, 1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        if (n_bad != 0 || sb.size() != 0)
            $display("FAIL: %0d miscompares, %0d unchecked",
                     n_bad, sb.size());
        else
            $display("PASS");
        $finish;
    end

endmodule
